// File: rtl/jtdd_mcu_bus_if.sv
// MCU bus bundle: core-side address/data, main-CPU shared RAM port and ROM handshake.
interface jtdd_mcu_bus_if #(
  parameter int SHW  = 9,
  parameter int ROMW = 14
);
  // MCU core side
  logic            mcu_cen;
  logic [15:0]     mcu_A;
  logic            mcu_rnw;
  logic            mcu_vma;
  logic [7:0]      mcu_dout;
  logic [7:0]      mcu_din;
  logic            cpu_cen;
  logic            mcu_halted;
  // Main CPU shared RAM side
  logic [SHW-1:0]  cpu_AB;
  logic            cpu_wrn;
  logic [7:0]      cpu_dout;
  logic            com_cs;
  logic [7:0]      shared_dout;
  // ROM side
  logic [ROMW-1:0] rom_addr;
  logic            rom_cs;
  logic [7:0]      rom_data;
  logic            rom_ok;

  modport master (
    output mcu_cen, mcu_A, mcu_rnw, mcu_vma, mcu_dout, mcu_halted,
    output cpu_AB, cpu_wrn, cpu_dout, com_cs, rom_data, rom_ok,
    input  mcu_din, cpu_cen, shared_dout, rom_addr, rom_cs
  );

  modport slave (
    input  mcu_cen, mcu_A, mcu_rnw, mcu_vma, mcu_dout, mcu_halted,
    input  cpu_AB, cpu_wrn, cpu_dout, com_cs, rom_data, rom_ok,
    output mcu_din, cpu_cen, shared_dout, rom_addr, rom_cs
  );
endinterface

// File: rtl/jtdd_mcu_bus.sv
// Bus controller for a 6801-class sub-CPU: decode, data-in mux, ROM wait
// with timeout, port registers, internal RAM, shared RAM and interrupt latches.
module jtdd_mcu_bus #(
  parameter int SHW       = 9,
  parameter int IRW       = 8,
  parameter int ROMW      = 14,
  parameter int NCH       = 2,
  parameter int TMO       = 255,
  parameter int HALT_GATE = 1
) (
  input  logic           clk,
  input  logic           mcu_rstb,
  jtdd_mcu_bus_if.slave  bus,
  output logic           mcu_nmi,
  output logic           mcu_irq,
  input  logic [NCH-1:0] irq_set,
  output logic           mcu_irqmain,
  output logic [7:0]     p6_dout,
  output logic           rom_err
);

  localparam logic [16:0] IR_END  = 17'(32'h40 + (32'd1 << IRW));
  localparam logic [7:0]  TMO_C   = 8'(TMO);
  localparam bit          TMO_EN  = (TMO != 0);
  localparam bit          HALT_EN = (HALT_GATE != 0);

  typedef enum logic {ST_RUN, ST_WAIT} rom_st_t;

  rom_st_t        st, st_nx;
  logic [7:0]     cnt, cnt_nx;
  logic           err_nx;
  logic           port_cs, iram_cs, sh_cs, rom_cs_i;
  logic           cpu_cen_i, mcu_wr, port_wr, mcu_sh_we, cpu_sh_we;
  logic [NCH-1:0] irq_p0, irq_p1, latch, clr;
  logic [7:0]     rf [32];
  logic [7:0]     iram [2**IRW];
  logic [7:0]     shram [2**SHW];
  logic [7:0]     iram_q, sh_q, din;
  logic [IRW-1:0] iram_a;
  logic [SHW-1:0] sh_a;

  assign iram_a      = IRW'(bus.mcu_A - 16'h0040);
  assign sh_a        = bus.mcu_A[SHW-1:0];
  assign cpu_cen_i   = bus.mcu_cen & ((st == ST_RUN) | ~mcu_rstb);
  assign mcu_wr      = cpu_cen_i & ~bus.mcu_rnw;
  assign port_wr     = mcu_wr & port_cs;
  assign mcu_sh_we   = mcu_wr & sh_cs;
  // MCU wins a same-address collision; main CPU writes may be gated by halt
  assign cpu_sh_we   = ~bus.cpu_wrn & bus.com_cs & (bus.mcu_halted | ~HALT_EN)
                     & ~(mcu_sh_we & (sh_a == bus.cpu_AB));
  assign clr         = (port_wr && bus.mcu_A[5:0] == 6'h16) ? bus.mcu_dout[NCH-1:0] : '0;
  assign bus.cpu_cen = cpu_cen_i;
  assign bus.mcu_din = din;
  assign bus.rom_cs  = rom_cs_i;
  assign bus.rom_addr = bus.mcu_A[ROMW-1:0];
  assign mcu_nmi     = latch[0];
  assign mcu_irqmain = p6_dout[1];

  generate
    if (NCH > 1) begin : g_irq
      assign mcu_irq = |latch[NCH-1:1];
    end else begin : g_noirq
      assign mcu_irq = 1'b0;
    end
  endgenerate

  // Address decode, qualified by a valid memory access
  always_comb begin
    port_cs  = bus.mcu_vma & (bus.mcu_A < 16'h0028);
    iram_cs  = bus.mcu_vma & (bus.mcu_A >= 16'h0040) & ({1'b0, bus.mcu_A} < IR_END);
    sh_cs    = bus.mcu_vma & (bus.mcu_A[15:12] == 4'h8);
    rom_cs_i = bus.mcu_vma & (bus.mcu_A[15:14] == 2'b11);
  end

  // Core read data: ports, then internal RAM, then shared RAM, else ROM
  always_comb begin
    din = bus.rom_data;
    if (port_cs) begin
      if (bus.mcu_A[5])                  din = 8'h00;
      else if (bus.mcu_A[4:0] == 5'h16)  din = 8'(latch);
      else if (bus.mcu_A[4:0] == 5'h17)  din = p6_dout;
      else                               din = rf[bus.mcu_A[4:0]];
    end else if (iram_cs) begin
      din = iram_q;
    end else if (sh_cs) begin
      din = sh_q;
    end
  end

  // ROM wait state register, timeout counter and sticky error
  always_ff @(posedge clk) begin
    if (!mcu_rstb) begin
      st      <= ST_RUN;
      cnt     <= 8'd0;
      rom_err <= 1'b0;
    end else begin
      st      <= st_nx;
      cnt     <= cnt_nx;
      rom_err <= err_nx;
    end
  end

  // ROM wait next state: stall while ROM is not ready, give up after TMO cycles
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    err_nx = rom_err;
    if (rom_cs_i && !bus.rom_ok) begin
      if (TMO_EN && cnt == TMO_C) begin
        st_nx  = ST_RUN;
        cnt_nx = 8'd0;
        err_nx = 1'b1;
      end else begin
        st_nx  = ST_WAIT;
        cnt_nx = cnt + 8'd1;
      end
    end else if (bus.rom_ok) begin
      st_nx  = ST_RUN;
      cnt_nx = 8'd0;
    end
  end

  // Interrupt edge detection and latches; a new edge beats a software clear
  always_ff @(posedge clk) begin
    if (!mcu_rstb) begin
      irq_p0 <= '0;
      irq_p1 <= '0;
      latch  <= '0;
    end else begin
      irq_p0 <= irq_set;
      irq_p1 <= irq_p0;
      latch  <= (latch & ~clr) | (irq_p0 & ~irq_p1);
    end
  end

  // Port 0x17 output register
  always_ff @(posedge clk) begin
    if (!mcu_rstb)                              p6_dout <= 8'h00;
    else if (port_wr && bus.mcu_A[5:0] == 6'h17) p6_dout <= bus.mcu_dout;
  end

  // Port register file, not reset; 0x20-0x27 are read-as-zero and not stored
  always_ff @(posedge clk) begin
    if (port_wr && !bus.mcu_A[5]) rf[bus.mcu_A[4:0]] <= bus.mcu_dout;
  end

  // Internal RAM with registered read
  always_ff @(posedge clk) begin
    if (mcu_wr && iram_cs) iram[iram_a] <= bus.mcu_dout;
    iram_q <= iram[iram_a];
  end

  // Dual-port shared RAM, registered reads on both sides
  always_ff @(posedge clk) begin
    if (cpu_sh_we) shram[bus.cpu_AB] <= bus.cpu_dout;
    if (mcu_sh_we) shram[sh_a] <= bus.mcu_dout;
    sh_q            <= shram[sh_a];
    bus.shared_dout <= shram[bus.cpu_AB];
  end

endmodule

// File: doc/jtdd_mcu_bus.md
Name: jtdd_mcu_bus

Overview:
Parametrised MCU-side bus controller for 6801-class sub-CPUs, used in Double Dragon-family cores. It sits between the MCU core and the rest of the system:
- address decoding and MCU data-in multiplexing;
- ROM wait-state handshake with timeout;
- internal RAM and port register file;
- dual-port shared RAM towards the main CPU;
- NCH edge-latched interrupt channels with software clear.
The CPU core itself is instantiated outside this block.

Parameters:
SHW, 9, shared RAM address width (2^SHW bytes, mapped at 8xxx, mirrored).
IRW, 8, internal RAM address width (mapped at 0x0040 .. 0x0040+2^IRW-1).
ROMW, 14, ROM address width (ROM at A[15:14]==2'b11).
NCH, 2, interrupt channels (1..8); channel 0 drives NMI, the rest are ORed to IRQ.
TMO, 255, ROM wait timeout in clk cycles (8-bit counter; 0 disables the timeout).
HALT_GATE, 1, 1 = main-CPU shared writes are allowed only while mcu_halted=1.

Ports:
clk  in  1  system clock
mcu_rstb  in  1  synchronous active-low reset
mcu_cen  in  1  raw MCU clock enable
mcu_A  in  16  core address
mcu_rnw  in  1  core read/not-write
mcu_vma  in  1  core valid memory access
mcu_dout  in  8  core write data
mcu_din  out  8  core read data
cpu_cen  out  1  gated clock enable to the core
mcu_halted  in  1  core halted status
mcu_nmi  out  1  NMI to core
mcu_irq  out  1  IRQ to core
irq_set  in  NCH  interrupt set requests (rising-edge sensitive)
cpu_AB  in  SHW  main CPU address
cpu_wrn  in  1  main CPU write strobe, active low
cpu_dout  in  8  main CPU write data
com_cs  in  1  main CPU shared RAM select
shared_dout  out  8  shared RAM read data to main CPU
mcu_irqmain  out  1  p6 bit 1, interrupt to main CPU
p6_dout  out  8  port 0x17 register
rom_addr  out  ROMW  equals mcu_A[ROMW-1:0]
rom_cs  out  1  ROM select
rom_data  in  8  ROM data
rom_ok  in  1  ROM data valid
rom_err  out  1  sticky ROM timeout flag

Behaviour:

Reset values:
- p6_dout=0, interrupt latches=0, mcu_nmi=mcu_irq=0.
- waitn=1, timeout counter=0, rom_err=0, edge detectors cleared.
- Port register file contents are not reset.

Decode (only when mcu_vma=1, combinational):
- port: A<0x28.
- intram: 0x40 <= A < 0x40+2^IRW.
- shared: A[15:12]==4'h8.
- rom_cs: A[15:14]==2'b11.
- With vma=0 all selects are 0.

mcu_din priority:
- port → 0x00-0x15 and 0x18-0x1F: register file [A[4:0]]; 0x16: {0, latch status}; 0x17: p6_dout; 0x20-0x27: 0x00.
- intram → RAM q.
- shared → shared q.
- otherwise → rom_data.

Port writes (vma & port & ~rnw & cpu_cen):
- Writes store into the register file.
- 0x17 also loads p6_dout.
- 0x16: each written 1 clears the corresponding interrupt latch.

Interrupts:
- irq_set[i] is registered; a 0→1 transition sets latch[i] on the following clk.
- If set and clear hit the same cycle, set wins.
- mcu_nmi = latch[0]; mcu_irq = OR of latch[NCH-1:1] (0 when NCH=1).

ROM wait:
- In a cycle with rom_cs & ~rom_ok: waitn←0 and the counter increments.
- rom_ok: waitn←1 and the counter clears.
- cpu_cen = mcu_cen & (waitn | ~mcu_rstb).
- If TMO≠0 and the counter reaches TMO: waitn←1, rom_err←1 (sticky until reset), the counter clears, and the core proceeds with the current rom_data.
- Reset during a wait releases the stall on the next clk.

RAMs:
- Internal RAM and the MCU port of the shared RAM read synchronously every clk (1-cycle latency, always valid before the next cpu_cen).
- Both are written when cpu_cen & ~rnw & their select is active.
- Main-CPU write to shared RAM requires ~cpu_wrn & com_cs & (mcu_halted | ~HALT_GATE).
- Write collision on the same shared address in the same cycle: the main-CPU write is suppressed and the MCU data is kept.
- shared_dout has 1-cycle latency.
- Address wrap-around: shared RAM uses A[SHW-1:0] (mirrored across 8xxx); internal RAM uses (A-0x40)[IRW-1:0].

Test Plan:
1. Reset, then MCU write 0x5A to 0x8003; main CPU reads cpu_AB=3 → shared_dout=0x5A one clk later; main write 0xA5 at cpu_AB=3 with mcu_halted=0 and HALT_GATE=1 → ignored, MCU reads back 0x5A.
2. mcu_halted=1 with simultaneous MCU and CPU writes to address 3 (0x11 vs 0x22) → MCU reads 0x11; a CPU write to address 4 → MCU reads 0x22 at 0x8004.
3. ROM fetch at 0xC123 with rom_ok low for 5 clk → cpu_cen held 0 for those cycles, rom_addr=0x0123, din=rom_data once rom_ok=1; rom_ok never asserted with TMO=255 → release after 255 cycles, rom_err=1 until reset.
4. Pulse irq_set[0] → mcu_nmi=1 two clk later; write 0x01 to port 0x16 → cleared; set and clear in the same cycle → remains 1; NCH=3, irq_set[2] → mcu_irq=1, read 0x16 → 0x04.
5. Write 0x02 to port 0x17 → p6_dout=0x02, mcu_irqmain=1; read 0x17 → 0x02; read 0x24 → 0x00; mid-operation reset → p6_dout=0, latches=0.
6. Internal RAM: write 0x77 at 0x0040 and 0x33 at 0x013F (IRW=8) → both read back; access to 0x0140 decodes as ROM default (not RAM).
